// File: rtl/viol_reset_seq_if.sv
// Bundle between the security monitors / CPU side and the violation reset sequencer.
// The master drives pc, requests and acknowledge; the slave returns the reset and the cause log.
interface viol_reset_seq_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
);
  logic [15:0]      pc;
  logic [N_REQ-1:0] req;
  logic             cause_ack;
  logic             sys_reset;
  logic             busy;
  logic [N_REQ-1:0] cause;
  logic             first_valid;
  logic [IDX_W-1:0] first_cause;
  logic [7:0]       viol_count;

  modport master (
    output pc, req, cause_ack,
    input  sys_reset, busy, cause, first_valid, first_cause, viol_count
  );

  modport slave (
    input  pc, req, cause_ack,
    output sys_reset, busy, cause, first_valid, first_cause, viol_count
  );
endinterface

// File: rtl/viol_reset_seq.sv
// Merges monitor violation requests into one stretched system reset, keeps the monitors
// disarmed until the CPU reaches the reset handler, and logs the violation cause.
module viol_reset_seq #(
  parameter int          N_REQ         = 4,
  parameter int          HOLD_CYCLES   = 8,
  parameter int          CNT_W         = 4,
  parameter int          IDX_W         = 2,
  parameter logic [15:0] RESET_HANDLER = 16'hFFFE
) (
  input logic              clk,
  input logic              rst,
  viol_reset_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    HOLD  = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_viol_inc;
  logic             w_any_req;
  logic             r_sys_reset;
  logic             r_busy;
  logic [N_REQ-1:0] r_cause;
  logic             r_first_valid;
  logic [IDX_W-1:0] r_first_cause;
  logic [7:0]       r_viol_count;

  // Bit 0 has the highest priority, so scan downwards and let the lowest set bit win.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign w_any_req = |bus.req;

  // Next-state and hold-counter logic.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_viol_inc   = 1'b0;
    case (r_state)
      ARMED: begin
        if (w_any_req) begin
          w_next_state = HOLD;
          w_next_cnt   = CNT_LOAD;
          w_viol_inc   = 1'b1;
        end else begin
          w_next_state = ARMED;
        end
      end
      HOLD: begin
        if (r_cnt != {CNT_W{1'b0}}) begin
          w_next_cnt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (!w_any_req) begin
          w_next_state = WAIT;
        end else begin
          // Stretch the reset while any monitor still requests.
          w_next_state = HOLD;
        end
      end
      WAIT: begin
        if (w_any_req) begin
          w_next_state = HOLD;
          w_next_cnt   = CNT_LOAD;
          w_viol_inc   = 1'b1;
        end else if (bus.pc == RESET_HANDLER) begin
          w_next_state = ARMED;
        end else begin
          w_next_state = WAIT;
        end
      end
      default: begin
        w_next_state = ARMED;
        w_next_cnt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and registered reset/busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARMED;
      r_cnt       <= {CNT_W{1'b0}};
      r_sys_reset <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_sys_reset <= (w_next_state == HOLD);
      r_busy      <= (w_next_state != ARMED);
    end
  end

  // Sticky cause log; a request arriving with the acknowledge survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cause       <= {N_REQ{1'b0}};
      r_first_valid <= 1'b0;
      r_first_cause <= {IDX_W{1'b0}};
    end else begin
      r_cause <= (bus.cause_ack ? {N_REQ{1'b0}} : r_cause) | bus.req;
      if (w_any_req && (!r_first_valid || bus.cause_ack)) begin
        r_first_valid <= 1'b1;
        r_first_cause <= lowest_idx(bus.req);
      end else if (bus.cause_ack) begin
        r_first_valid <= 1'b0;
      end else begin
        r_first_valid <= r_first_valid;
      end
    end
  end

  // Saturating violation counter; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_viol_count <= 8'd0;
    end else if (w_viol_inc && (r_viol_count != 8'hFF)) begin
      r_viol_count <= r_viol_count + 8'd1;
    end else begin
      r_viol_count <= r_viol_count;
    end
  end

  assign bus.sys_reset   = r_sys_reset;
  assign bus.busy        = r_busy;
  assign bus.cause       = r_cause;
  assign bus.first_valid = r_first_valid;
  assign bus.first_cause = r_first_cause;
  assign bus.viol_count  = r_viol_count;

endmodule

// File: doc/viol_reset_seq.md
# viol_reset_seq

Reset sequencer shared by the hardware security monitors: access-control, atomicity and key-protection. It merges their violation-reset requests into one system reset toward the openMSP430 core. It holds that reset for a guaranteed minimum number of cycles, then keeps the monitors disarmed until the CPU fetches from the reset vector. It also keeps a sticky record of the cause, a first-offender index and a saturating violation counter for the trusted software's post-reset inspection.

## Interface
Parameters:
- N_REQ, 4 — number of monitor requesters; bit 0 has the highest priority.
- HOLD_CYCLES, 8 — minimum sys_reset assertion length in cycles; legal range 1..2^CNT_W.
- CNT_W, 4 — hold counter width.
- IDX_W, 2 — width of first_cause; must be ≥ clog2(N_REQ).
- RESET_HANDLER, 16'hFFFE — PC value that re-arms the sequencer.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- pc  in  16  current CPU program counter.
- req  in  N_REQ  violation-reset requests, one per monitor; level-sensitive.
- cause_ack  in  1  one-cycle pulse from trusted software that clears the sticky log.
- sys_reset  out  1  registered reset request to the core.
- busy  out  1  high whenever state ≠ ARMED.
- cause  out  N_REQ  sticky OR of every req bit seen since the last clear.
- first_valid  out  1  first_cause holds a valid index.
- first_cause  out  IDX_W  lowest set req index of the first violation since the last clear.
- viol_count  out  8  number of violation entries into HOLD; saturates at 255.

## Operation
States:
- ARMED (reset state).
  - |req → HOLD; cnt ← HOLD_CYCLES-1; viol_count += 1, saturating.
  - Otherwise stay in ARMED.
- HOLD.
  - cnt ≠ 0 → cnt -= 1.
  - cnt == 0 and req == 0 → WAIT.
  - cnt == 0 and req ≠ 0 → stay in HOLD with cnt held at 0 (reset is stretched while any monitor still requests).
- WAIT.
  - req ≠ 0 → HOLD; cnt ← HOLD_CYCLES-1; viol_count += 1 (counts as a new violation).
  - Else pc == RESET_HANDLER → ARMED.
  - Else stay in WAIT.

Outputs:
- sys_reset = registered (next_state == HOLD).
- busy = registered (next_state ≠ ARMED).
- In HOLD, new req bits are ORed into cause; viol_count does not change.

Logging:
- Every cycle: cause ← (cause_ack ? 0 : cause) | req. A new req in the same cycle as cause_ack therefore wins.
- When |req and (first_valid == 0 or cause_ack): first_valid ← 1, first_cause ← lowest set bit index of req.
- cause_ack with req == 0: first_valid ← 0; first_cause keeps its value.
- cause_ack never clears viol_count. Only rst clears viol_count.

Reset (rst high at a clock edge):
- state ARMED, cnt 0, sys_reset 0, busy 0, cause 0, first_valid 0, first_cause 0, viol_count 0.
- rst overrides everything, including mid-HOLD; the sequencer is ARMED on the next cycle.

## Timing
- req is first high at edge t while ARMED. sys_reset is high for cycles t+1 … t+HOLD_CYCLES, exactly HOLD_CYCLES cycles if req is low by the cycle where cnt reaches 0.
- Otherwise sys_reset stays high until the first cycle with cnt == 0 and req == 0, and falls on the following cycle.
- cause and first_cause update at t+1, the same cycle as sys_reset.
- Re-arm: pc == RESET_HANDLER and req == 0 sampled in WAIT → busy low the next cycle.
- pc == RESET_HANDLER while in HOLD is ignored.
- HOLD_CYCLES == 1: a single-cycle pulse when req lasts one cycle.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- rst, then req=4'b0100 for 1 cycle at t=10 → sys_reset high cycles 11–18; cause=4'b0100; first_cause=2; first_valid=1; viol_count=1; pc=16'hFFFE at cycle 25 → busy low at 26.
- req=4'b0110 held for 20 cycles → sys_reset stays high until the cycle after req drops; first_cause=1; viol_count=1 (not 20).
- While in WAIT, req=4'b1000 pulses → re-enter HOLD for 8 cycles; viol_count=2; cause=4'b1100; first_cause unchanged at 2.
- cause_ack in the same cycle as req=4'b0001 → cause=4'b0001; first_cause=0; first_valid=1.
- rst asserted during HOLD cycle 3 → next cycle sys_reset=0, busy=0, cause=0, viol_count=0.
- 300 separate violations, each followed by pc=16'hFFFE → viol_count=255 and stays there; HOLD_CYCLES=1 build → each sys_reset pulse lasts 1 cycle.
